alu_stack_ctrl: RTL and testbench
=================================

Name: alu_stack_ctrl

Overview:
Operand-stack controller that drives the combinational ALU from the stack side.
- Holds a small register-file stack and accepts push/pop/ALU commands over a valid/ready handshake.
- For ALU commands, presents NOS/TOS and the function code to the ALU, then writes the ALU result back as the new TOS.
- Sits between the instruction decoder and the ALU in the stack processor datapath.

Parameters:
WIDTH, 16, data width; matches ALU operand/result width
DEPTH, 8, stack entries; minimum 2
SPW, $clog2(DEPTH+1), stack-pointer/depth width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 PUSH, 01 POP, 10 ALU, 11 DUP
cmd_func  in  4  ALU function for op ALU: 0 R1, 1 R2, 2 ADD, 3 SUB, 4 MUL, 5 DIV
cmd_data  in  WIDTH  immediate for PUSH
done  out  1  one-cycle pulse when a command retires, including errored commands
tos  out  WIDTH  top of stack; 0 when empty
depth  out  SPW  current entry count, 0..DEPTH
err_ovf  out  1  sticky overflow flag
err_unf  out  1  sticky underflow flag
err_clr  in  1  synchronous clear of both sticky flags
alu_func  out  4  function code to ALU
alu_i0  out  WIDTH  ALU operand 0 = NOS, the entry below TOS
alu_i1  out  WIDTH  ALU operand 1 = TOS
alu_o0  in  WIDTH  combinational ALU result

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE, sp=0.
  - done, err_ovf, err_unf, alu_func, alu_i0, alu_i1 all 0.
  - cmd_ready=0 while rst_n low.
  - Storage contents are don't-care.
- Reset mid-operation aborts the command: no writeback, no done.
- cmd_ready = rst_n && state==IDLE. A command is accepted on a rising edge with cmd_valid && cmd_ready.
- States and transitions:
  - IDLE, on accept:
    - PUSH, sp<DEPTH: mem[sp]=cmd_data, sp+1.
    - POP, sp>0: sp-1.
    - DUP, sp in 1..DEPTH-1: mem[sp]=mem[sp-1], sp+1.
    - Each of these goes to DONE.
    - ALU with sp>=2: register alu_i0=mem[sp-2], alu_i1=mem[sp-1], alu_func=cmd_func; go to EXEC.
  - EXEC: mem[sp-2]=alu_o0, sp-1; go to DONE. alu_* outputs stay stable throughout EXEC.
  - DONE: done=1 for this cycle only; go to IDLE.
- Latency: done is asserted the 2nd cycle after accept for PUSH/POP/DUP, and the 3rd cycle after accept for ALU. Next accept is possible in the cycle after done.
- Error cases: stack unchanged, flag set, go to DONE (done still pulses).
  - Overflow (err_ovf): PUSH with sp==DEPTH; DUP with sp==DEPTH.
  - Underflow (err_unf): POP with sp==0; DUP with sp==0; ALU with sp<2.
- Sticky flags:
  - err_clr clears both flags.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag is set).
- Arithmetic: the controller does none itself. The result is exactly alu_o0, already WIDTH bits, so MUL wraps modulo 2^WIDTH. Unimplemented func codes (including DIV) write back whatever the ALU returns, currently 0.
- tos and depth are registered-state views: tos = sp>0 ? mem[sp-1] : 0; depth = sp. Both update on the edge that changes sp.
- cmd_* inputs are ignored when cmd_ready=0.

Optional Feature:
STACK_DUP_EN
- Defined: DUP behaves as above.
- Undefined: cmd_op 11 is illegal. It sets err_unf, leaves the stack unchanged and pulses done, with the same latency as POP. DUP storage logic is not built.

Test Plan:
- Reset, then PUSH 7, PUSH 3, ALU func=3 (SUB) -> alu_i0=7 and alu_i1=3 during EXEC; done 3 cycles after accept; tos=4, depth=1.
- PUSH 300, PUSH 300, ALU func=4 (MUL) -> tos=24464 (90000 mod 65536), depth=1, no error flags.
- DEPTH=4: five PUSHes of 1..5 -> 5th raises err_ovf, depth=4, tos=4; done still pulses. Then err_clr -> err_ovf=0.
- Single PUSH 9, then ALU func=2 -> err_unf=1, depth=1, tos=9, alu_* outputs not updated; POP, then POP -> second POP keeps err_unf=1, depth=0, tos=0.
- PUSH 5, PUSH 6, ALU ADD, assert rst_n low during EXEC -> no done, depth=0, tos=0, cmd_ready=0 while low; after release, cmd_ready=1 and PUSH 1 gives tos=1.
- PUSH 0x1234, DUP -> with STACK_DUP_EN: depth=2, tos=0x1234; without it: err_unf=1, depth=1.

Source files
------------

// File: rtl/alu_stack_ctrl.sv
// Operand-stack controller feeding a combinational ALU over valid/ready.
// Optional DUP command built when STACK_DUP_EN is defined.
module alu_stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [3:0]                   cmd_func,
  input  logic [WIDTH-1:0]             cmd_data,
  output logic                         done,
  output logic [WIDTH-1:0]             tos,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err_ovf,
  output logic                         err_unf,
  input  logic                         err_clr,
  output logic [3:0]                   alu_func,
  output logic [WIDTH-1:0]             alu_i0,
  output logic [WIDTH-1:0]             alu_i1,
  input  logic [WIDTH-1:0]             alu_o0
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           nstate;
  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] mem [DEPTH];

  logic accept;
  logic full;
  logic empty;
  logic lt2;
  logic op_push;
  logic op_pop;
  logic op_alu;
  logic op_dup;

  logic do_push;
  logic do_pop;
  logic do_load;
  logic do_wb;
  logic set_ovf;
  logic set_unf;
`ifdef STACK_DUP_EN
  logic do_dup;
`endif

  assign cmd_ready = rst_n && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign full      = (sp == SPW'(DEPTH));
  assign empty     = (sp == '0);
  assign lt2       = (sp < SPW'(2));

  assign op_push = (cmd_op == 2'b00);
  assign op_pop  = (cmd_op == 2'b01);
  assign op_alu  = (cmd_op == 2'b10);
  assign op_dup  = (cmd_op == 2'b11);

  assign done  = (state == DONE);
  assign depth = sp;
  assign tos   = empty ? '0 : mem[AW'(sp - SPW'(1))];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next state and per-cycle stack actions
  always_comb begin
    nstate  = state;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_load = 1'b0;
    do_wb   = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
`ifdef STACK_DUP_EN
    do_dup  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          nstate = DONE;
          unique case (1'b1)
            op_push: begin
              if (full) set_ovf = 1'b1;
              else      do_push = 1'b1;
            end
            op_pop: begin
              if (empty) set_unf = 1'b1;
              else       do_pop  = 1'b1;
            end
            op_alu: begin
              if (lt2) begin
                set_unf = 1'b1;
              end else begin
                do_load = 1'b1;
                nstate  = EXEC;
              end
            end
            op_dup: begin
`ifdef STACK_DUP_EN
              if (empty)     set_unf = 1'b1;
              else if (full) set_ovf = 1'b1;
              else           do_dup  = 1'b1;
`else
              set_unf = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        do_wb  = 1'b1;
        nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Stack pointer tracks net pushes minus pops/ALU merges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else begin
`ifdef STACK_DUP_EN
      if (do_push || do_dup)  sp <= sp + SPW'(1);
`else
      if (do_push)            sp <= sp + SPW'(1);
`endif
      else if (do_pop || do_wb) sp <= sp - SPW'(1);
    end
  end

  // Stack storage; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[AW'(sp)] <= cmd_data;
`ifdef STACK_DUP_EN
    if (do_dup)  mem[AW'(sp)] <= mem[AW'(sp - SPW'(1))];
`endif
    if (do_wb)   mem[AW'(sp - SPW'(2))] <= alu_o0;
  end

  // ALU operand latch, held stable through EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_func <= '0;
      alu_i0   <= '0;
      alu_i1   <= '0;
    end else if (do_load) begin
      alu_func <= cmd_func;
      alu_i0   <= mem[AW'(sp - SPW'(2))];
      alu_i1   <= mem[AW'(sp - SPW'(1))];
    end
  end

  // Sticky error flags; a fresh error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (set_ovf)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (set_unf)      err_unf <= 1'b1;
      else if (err_clr) err_unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Directed bench for alu_stack_ctrl with a DEPTH=4 stack.
// Includes a behavioural ALU on the alu_* side.
module tb_alu_stack_ctrl;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int SPW = $clog2(D+1);

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] ALU  = 2'b10;
  localparam logic [1:0] DUP  = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = '0;
  logic [3:0]     cmd_func = '0;
  logic [W-1:0]   cmd_data = '0;
  logic           done;
  logic [W-1:0]   tos;
  logic [SPW-1:0] depth;
  logic           err_ovf;
  logic           err_unf;
  logic           err_clr = 1'b0;
  logic [3:0]     alu_func;
  logic [W-1:0]   alu_i0;
  logic [W-1:0]   alu_i1;
  logic [W-1:0]   alu_o0;

  int total = 0;
  int bad = 0;

  logic [W-1:0] s_i0;
  logic [W-1:0] s_i1;
  logic [3:0]   s_fn;

  always #5 clk = ~clk;

  // Reference ALU: R1, R2, ADD, SUB, MUL (wraps), others 0
  always_comb begin
    alu_o0 = '0;
    case (alu_func)
      4'd0: alu_o0 = alu_i0;
      4'd1: alu_o0 = alu_i1;
      4'd2: alu_o0 = alu_i0 + alu_i1;
      4'd3: alu_o0 = alu_i0 - alu_i1;
      4'd4: alu_o0 = W'(alu_i0 * alu_i1);
      default: alu_o0 = '0;
    endcase
  end

  alu_stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_func(cmd_func), .cmd_data(cmd_data),
    .done(done), .tos(tos), .depth(depth),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr),
    .alu_func(alu_func), .alu_i0(alu_i0), .alu_i1(alu_i1),
    .alu_o0(alu_o0)
  );

  // lat counts the accept cycle as cycle 1; 99 means done never came
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] fn,
                        input logic [W-1:0] dat, input logic clr,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_func  = fn;
    cmd_data  = dat;
    err_clr   = clr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    lat = 99;
    for (int i = 2; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) begin
        s_i0 = alu_i0;
        s_i1 = alu_i1;
        s_fn = alu_func;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%0b exp=0", cmd_ready);
    end
    total++;
    if ({done, err_ovf, err_unf} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000", {done, err_ovf, err_unf});
    end
    total++;
    if (depth !== '0 || tos !== '0) begin
      bad++; $display("FAIL rst_stack got=%0d/%0h exp=0/0", depth, tos);
    end
    total++;
    if (alu_i0 !== '0 || alu_i1 !== '0 || alu_func !== '0) begin
      bad++; $display("FAIL rst_alu got=%0h/%0h/%0h exp=0/0/0", alu_i0, alu_i1, alu_func);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready got=%0b exp=1", cmd_ready);
    end
  endtask

  task automatic test_sub();
    int lat;
    apply_reset();
    do_cmd(PUSH, 4'd0, 16'd7, 1'b0, lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL push_lat got=%0d exp=2", lat);
    end
    do_cmd(PUSH, 4'd0, 16'd3, 1'b0, lat);
    do_cmd(ALU, 4'd3, 16'd0, 1'b0, lat);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL alu_lat got=%0d exp=3", lat);
    end
    total++;
    if (s_i0 !== 16'd7 || s_i1 !== 16'd3 || s_fn !== 4'd3) begin
      bad++; $display("FAIL sub_operands got=%0d/%0d/%0d exp=7/3/3", s_i0, s_i1, s_fn);
    end
    total++;
    if (tos !== 16'd4 || depth !== 3'd1) begin
      bad++; $display("FAIL sub_result got=%0d/%0d exp=4/1", tos, depth);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_pulse got=%0b exp=0", done);
    end
  endtask

  task automatic test_mul();
    int lat;
    apply_reset();
    do_cmd(PUSH, 4'd0, 16'd300, 1'b0, lat);
    do_cmd(PUSH, 4'd0, 16'd300, 1'b0, lat);
    do_cmd(ALU, 4'd4, 16'd0, 1'b0, lat);
    total++;
    if (tos !== 16'd24464 || depth !== 3'd1) begin
      bad++; $display("FAIL mul_wrap got=%0d/%0d exp=24464/1", tos, depth);
    end
    total++;
    if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      bad++; $display("FAIL mul_flags got=%b%b exp=00", err_ovf, err_unf);
    end
  endtask

  task automatic test_overflow();
    int lat;
    apply_reset();
    for (int i = 1; i <= 4; i++) do_cmd(PUSH, 4'd0, W'(i), 1'b0, lat);
    total++;
    if (err_ovf !== 1'b0 || depth !== 3'd4) begin
      bad++; $display("FAIL full_no_ovf got=%0b/%0d exp=0/4", err_ovf, depth);
    end
    do_cmd(PUSH, 4'd0, 16'd5, 1'b0, lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL ovf_done_lat got=%0d exp=2", lat);
    end
    total++;
    if (err_ovf !== 1'b1 || depth !== 3'd4 || tos !== 16'd4) begin
      bad++; $display("FAIL ovf_state got=%0b/%0d/%0d exp=1/4/4", err_ovf, depth, tos);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%0b exp=0", err_ovf);
    end
    do_cmd(PUSH, 4'd0, 16'd6, 1'b1, lat);
    total++;
    if (err_ovf !== 1'b1 || tos !== 16'd4) begin
      bad++; $display("FAIL ovf_beats_clr got=%0b/%0d exp=1/4", err_ovf, tos);
    end
  endtask

  task automatic test_underflow();
    int lat;
    apply_reset();
    do_cmd(PUSH, 4'd0, 16'd9, 1'b0, lat);
    do_cmd(ALU, 4'd2, 16'd0, 1'b0, lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL unf_alu_lat got=%0d exp=2", lat);
    end
    total++;
    if (err_unf !== 1'b1 || depth !== 3'd1 || tos !== 16'd9) begin
      bad++; $display("FAIL unf_alu got=%0b/%0d/%0d exp=1/1/9", err_unf, depth, tos);
    end
    total++;
    if (alu_func !== 4'd0 || alu_i1 !== '0 || alu_i0 !== '0) begin
      bad++; $display("FAIL unf_alu_hold got=%0h/%0h/%0h exp=0/0/0", alu_func, alu_i0, alu_i1);
    end
    do_cmd(POP, 4'd0, 16'd0, 1'b0, lat);
    total++;
    if (depth !== 3'd0 || tos !== '0) begin
      bad++; $display("FAIL pop_empty got=%0d/%0h exp=0/0", depth, tos);
    end
    do_cmd(POP, 4'd0, 16'd0, 1'b0, lat);
    total++;
    if (err_unf !== 1'b1 || depth !== 3'd0 || tos !== '0 || lat !== 2) begin
      bad++; $display("FAIL unf_pop got=%0b/%0d/%0h/%0d exp=1/0/0/2", err_unf, depth, tos, lat);
    end
    total++;
    if (err_ovf !== 1'b0) begin
      bad++; $display("FAIL unf_no_ovf got=%0b exp=0", err_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    apply_reset();
    do_cmd(PUSH, 4'd0, 16'd5, 1'b0, lat);
    do_cmd(PUSH, 4'd0, 16'd6, 1'b0, lat);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = ALU;
    cmd_func  = 4'd2;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (alu_i0 !== 16'd5 || alu_i1 !== 16'd6) begin
      bad++; $display("FAIL mid_exec_ops got=%0d/%0d exp=5/6", alu_i0, alu_i1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b0 || depth !== '0 || tos !== '0) begin
      bad++; $display("FAIL mid_rst_state got=%0b/%0d/%0h exp=0/0/0", cmd_ready, depth, tos);
    end
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_rst_abort got=done%0b/rdy%0b exp=done0/rdy1", seen, cmd_ready);
    end
    do_cmd(PUSH, 4'd0, 16'd1, 1'b0, lat);
    total++;
    if (tos !== 16'd1 || depth !== 3'd1) begin
      bad++; $display("FAIL mid_rst_push got=%0d/%0d exp=1/1", tos, depth);
    end
  endtask

  task automatic test_dup();
    int lat;
    apply_reset();
    do_cmd(PUSH, 4'd0, 16'h1234, 1'b0, lat);
    do_cmd(DUP, 4'd0, 16'd0, 1'b0, lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL dup_lat got=%0d exp=2", lat);
    end
`ifdef STACK_DUP_EN
    total++;
    if (depth !== 3'd2 || tos !== 16'h1234 || err_unf !== 1'b0) begin
      bad++; $display("FAIL dup_on got=%0d/%0h/%0b exp=2/1234/0", depth, tos, err_unf);
    end
`else
    total++;
    if (depth !== 3'd1 || tos !== 16'h1234 || err_unf !== 1'b1) begin
      bad++; $display("FAIL dup_off got=%0d/%0h/%0b exp=1/1234/1", depth, tos, err_unf);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_reset();
    do_cmd(PUSH, 4'd0, 16'd10, 1'b0, lat);
    do_cmd(PUSH, 4'd0, 16'd3, 1'b0, lat);
    do_cmd(ALU, 4'd0, 16'd0, 1'b0, lat);
    total++;
    if (tos !== 16'd10 || lat !== 3) begin
      bad++; $display("FAIL r1 got=%0d/%0d exp=10/3", tos, lat);
    end
    do_cmd(PUSH, 4'd0, 16'd3, 1'b0, lat);
    do_cmd(ALU, 4'd1, 16'd0, 1'b0, lat);
    total++;
    if (tos !== 16'd3 || depth !== 3'd1) begin
      bad++; $display("FAIL r2 got=%0d/%0d exp=3/1", tos, depth);
    end
    do_cmd(PUSH, 4'd0, 16'd8, 1'b0, lat);
    do_cmd(ALU, 4'd5, 16'd0, 1'b0, lat);
    total++;
    if (tos !== 16'd0 || depth !== 3'd1) begin
      bad++; $display("FAIL div_zero got=%0d/%0d exp=0/1", tos, depth);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL after_done got=rdy%0b/done%0b exp=rdy1/done0", cmd_ready, done);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_mul();
    test_overflow();
    test_underflow();
    test_reset_mid();
    test_dup();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
